// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU/PC-source encodings, link register
// default, and the per-stage control bundle carried through the pipeline.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_LUI  = 4'd9
  } aluc_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JR     = 2'd2,
    PC_JUMP   = 2'd3
  } pcsrc_e;

  localparam int LINK_REG_DEFAULT = 31;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       jal;
    logic       shift;
    logic [3:0] aluc;
    logic [4:0] dest;
  } ctrl_t;

  // Field masks: EX/MEM keeps memory/writeback controls, MEM/WB keeps writeback only.
  localparam ctrl_t KEEP_ALL = '1;
  localparam ctrl_t KEEP_MEM = '{valid: 1'b1, wreg: 1'b1, m2reg: 1'b1, wmem: 1'b1,
                                 aluimm: 1'b0, jal: 1'b0, shift: 1'b0,
                                 aluc: 4'h0, dest: 5'h1f};
  localparam ctrl_t KEEP_WB  = '{valid: 1'b1, wreg: 1'b1, m2reg: 1'b1, wmem: 1'b0,
                                 aluimm: 1'b0, jal: 1'b0, shift: 1'b0,
                                 aluc: 4'h0, dest: 5'h1f};

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-bundle link between pipeline stages; master drives, slave reads.
interface ctrl_pipe_if;
  import mips_pkg::*;

  // valid marks a real instruction. There is no ready: ID/EX takes a bubble
  // instead of the bundle while wpcir is low, and later stages always accept.
  ctrl_t bundle;

  modport master (output bundle);
  modport slave  (input  bundle);
endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register; KEEP selects which fields this stage carries.
module ctrl_stage_reg
  import mips_pkg::*;
#(
  parameter ctrl_t KEEP = '1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        bubble,
  ctrl_pipe_if.slave  d,
  ctrl_pipe_if.master q
);

  ctrl_t q_r;

  always_ff @(posedge clk) begin
    if (!clrn || bubble) begin
      q_r <= '0;
    end else begin
      q_r <= ctrl_t'(d.bundle & KEEP);
    end
  end

  assign q.bundle = q_r;

endmodule

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use bubble insertion.
// Optional perf counters enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe
  import mips_pkg::*;
#(
  parameter int PERF_W   = 16,
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              id_valid,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic              regrt,
  input  logic              jal,
  input  logic              shift,
  input  logic [3:0]        aluc,
  input  logic [4:0]        rd,
  input  logic [4:0]        rt,
  input  logic              wpcir,
  output logic [4:0]        edestReg,
  output logic [4:0]        mdestReg,
  output logic [4:0]        wdestReg,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic              ejal,
  output logic              eshift,
  output logic [3:0]        ealuc,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] retire_cnt
);

  ctrl_pipe_if id_bus ();
  ctrl_pipe_if ex_bus ();
  ctrl_pipe_if mem_bus ();
  ctrl_pipe_if wb_bus ();

  logic [4:0] id_dest;

  always_comb begin
    id_dest = rd;
    if (jal) begin
      id_dest = 5'(LINK_REG);
    end else if (regrt) begin
      id_dest = rt;
    end
  end

  assign id_bus.bundle = '{valid: id_valid, wreg: wreg, m2reg: m2reg, wmem: wmem,
                           aluimm: aluimm, jal: jal, shift: shift,
                           aluc: aluc, dest: id_dest};

  ctrl_stage_reg #(.KEEP(KEEP_ALL)) u_id_ex (
    .clk    (clk),
    .clrn   (clrn),
    .bubble (!wpcir),
    .d      (id_bus),
    .q      (ex_bus)
  );

  // Downstream stages never stall: they drain whatever EX held.
  ctrl_stage_reg #(.KEEP(KEEP_MEM)) u_ex_mem (
    .clk    (clk),
    .clrn   (clrn),
    .bubble (1'b0),
    .d      (ex_bus),
    .q      (mem_bus)
  );

  ctrl_stage_reg #(.KEEP(KEEP_WB)) u_mem_wb (
    .clk    (clk),
    .clrn   (clrn),
    .bubble (1'b0),
    .d      (mem_bus),
    .q      (wb_bus)
  );

  assign edestReg = ex_bus.bundle.dest;
  assign ewreg    = ex_bus.bundle.valid & ex_bus.bundle.wreg;
  assign em2reg   = ex_bus.bundle.m2reg;
  assign ewmem    = ex_bus.bundle.valid & ex_bus.bundle.wmem;
  assign ealuimm  = ex_bus.bundle.aluimm;
  assign ejal     = ex_bus.bundle.jal;
  assign eshift   = ex_bus.bundle.shift;
  assign ealuc    = ex_bus.bundle.aluc;

  assign mdestReg = mem_bus.bundle.dest;
  assign mwreg    = mem_bus.bundle.valid & mem_bus.bundle.wreg;
  assign mm2reg   = mem_bus.bundle.m2reg;
  assign mwmem    = mem_bus.bundle.valid & mem_bus.bundle.wmem;

  assign wdestReg = wb_bus.bundle.dest;
  assign wwreg    = wb_bus.bundle.valid & wb_bus.bundle.wreg;
  assign wm2reg   = wb_bus.bundle.m2reg;

  // Fields masked to zero in later stages are intentionally left unread.
  wire unused_bits = ^{mem_bus.bundle.aluimm, mem_bus.bundle.jal, mem_bus.bundle.shift,
                       mem_bus.bundle.aluc, wb_bus.bundle.wmem, wb_bus.bundle.aluimm,
                       wb_bus.bundle.jal, wb_bus.bundle.shift, wb_bus.bundle.aluc};

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] retire_q;

  // Retire counts MEM/WB loading a valid entry, i.e. EX/MEM currently valid.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      if (!wpcir && (stall_q != '1)) begin
        stall_q <= stall_q + PERF_W'(1);
      end
      if (mem_bus.bundle.valid && (retire_q != '1)) begin
        retire_q <= retire_q + PERF_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign retire_cnt = retire_q;
`else
  assign stall_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios then random traffic
// against a stage-list reference model.
module tb_ctrl_pipe;
  import mips_pkg::*;

  localparam int PW      = 4;
  localparam int CNT_MAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if stim_if ();
  logic       regrt, wpcir;
  logic [4:0] rd, rt;

  logic [4:0]    edestReg, mdestReg, wdestReg;
  logic          ewreg, em2reg, ewmem, ealuimm, ejal, eshift;
  logic [3:0]    ealuc;
  logic          mwreg, mm2reg, mwmem, wwreg, wm2reg;
  logic [PW-1:0] stall_cnt, retire_cnt;

  ctrl_pipe #(.PERF_W(PW), .LINK_REG(31)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .id_valid   (stim_if.bundle.valid),
    .wreg       (stim_if.bundle.wreg),
    .m2reg      (stim_if.bundle.m2reg),
    .wmem       (stim_if.bundle.wmem),
    .aluimm     (stim_if.bundle.aluimm),
    .regrt      (regrt),
    .jal        (stim_if.bundle.jal),
    .shift      (stim_if.bundle.shift),
    .aluc       (stim_if.bundle.aluc),
    .rd         (rd),
    .rt         (rt),
    .wpcir      (wpcir),
    .edestReg   (edestReg),
    .mdestReg   (mdestReg),
    .wdestReg   (wdestReg),
    .ewreg      (ewreg),
    .em2reg     (em2reg),
    .ewmem      (ewmem),
    .ealuimm    (ealuimm),
    .ejal       (ejal),
    .eshift     (eshift),
    .ealuc      (ealuc),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .stall_cnt  (stall_cnt),
    .retire_cnt (retire_cnt)
  );

  typedef struct packed {
    logic       v;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       jal;
    logic       shift;
    logic [3:0] aluc;
    logic [4:0] dest;
  } ent_t;

  ent_t ex_m, mem_m, wb_m;
  int   stall_m, retire_m;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? x : x + 1;
  endfunction

  function automatic ent_t id_entry();
    ent_t e;
    e.v      = stim_if.bundle.valid;
    e.wreg   = stim_if.bundle.wreg;
    e.m2reg  = stim_if.bundle.m2reg;
    e.wmem   = stim_if.bundle.wmem;
    e.aluimm = stim_if.bundle.aluimm;
    e.jal    = stim_if.bundle.jal;
    e.shift  = stim_if.bundle.shift;
    e.aluc   = stim_if.bundle.aluc;
    e.dest   = stim_if.bundle.jal ? 5'd31 : (regrt ? rt : rd);
    return e;
  endfunction

  // Advance one edge, update the model, then compare every output group.
  task automatic tick();
    ent_t e;
    logic [31:0] obs, exp;
    @(posedge clk);
    if (!clrn) begin
      ex_m = '0; mem_m = '0; wb_m = '0;
      stall_m = 0; retire_m = 0;
    end else begin
      if (mem_m.v) retire_m = sat_inc(retire_m);
      if (!wpcir) stall_m = sat_inc(stall_m);
      e = '0;
      e.v = mem_m.v; e.wreg = mem_m.wreg; e.m2reg = mem_m.m2reg; e.dest = mem_m.dest;
      wb_m = e;
      e = '0;
      e.v = ex_m.v; e.wreg = ex_m.wreg; e.m2reg = ex_m.m2reg; e.wmem = ex_m.wmem;
      e.dest = ex_m.dest;
      mem_m = e;
      ex_m = wpcir ? id_entry() : '0;
    end
    #1;
    obs = {17'd0, edestReg, ewreg, em2reg, ewmem, ealuimm, ejal, eshift, ealuc};
    exp = {17'd0, ex_m.dest, ex_m.v & ex_m.wreg, ex_m.m2reg, ex_m.v & ex_m.wmem,
           ex_m.aluimm, ex_m.jal, ex_m.shift, ex_m.aluc};
    check("ex_stage", obs, exp);
    obs = {24'd0, mdestReg, mwreg, mm2reg, mwmem};
    exp = {24'd0, mem_m.dest, mem_m.v & mem_m.wreg, mem_m.m2reg, mem_m.v & mem_m.wmem};
    check("mem_stage", obs, exp);
    obs = {25'd0, wdestReg, wwreg, wm2reg};
    exp = {25'd0, wb_m.dest, wb_m.v & wb_m.wreg, wb_m.m2reg};
    check("wb_stage", obs, exp);
`ifdef CTRL_PIPE_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    check("retire_cnt", 32'(retire_cnt), 32'(retire_m));
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
    check("retire_cnt", 32'(retire_cnt), 32'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic w, input logic m2, input logic wm,
                       input logic ai, input logic rg, input logic j, input logic sh,
                       input logic [3:0] a, input logic [4:0] d, input logic [4:0] t,
                       input logic stall_n);
    stim_if.bundle.valid  = v;
    stim_if.bundle.wreg   = w;
    stim_if.bundle.m2reg  = m2;
    stim_if.bundle.wmem   = wm;
    stim_if.bundle.aluimm = ai;
    stim_if.bundle.jal    = j;
    stim_if.bundle.shift  = sh;
    stim_if.bundle.aluc   = a;
    stim_if.bundle.dest   = '0;
    regrt = rg;
    rd    = d;
    rt    = t;
    wpcir = stall_n;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b1);
  endtask

  initial begin
    ex_m = '0; mem_m = '0; wb_m = '0;
    stall_m = 0; retire_m = 0;
    clrn = 1'b0;
    drive_idle();
    tick();
    tick();
    check("reset_ewreg", 32'(ewreg), 32'd0);
    check("reset_wdest", 32'(wdestReg), 32'd0);

    // lw r5: EX after one edge, WB after three
    clrn = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD, 5'd9, 5'd5, 1'b1);
    tick();
    check("lw_edest", 32'(edestReg), 32'd5);
    check("lw_em2reg", 32'(em2reg), 32'd1);
    drive_idle();
    tick();
    tick();
    check("lw_wdest", 32'(wdestReg), 32'd5);
    check("lw_wwreg", 32'(wwreg), 32'd1);

    // add r7 followed by two stall cycles with junk on the ID inputs
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5'd7, 5'd2, 1'b1);
    tick();
    check("add_edest", 32'(edestReg), 32'd7);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_SRA, 5'd9, 5'd9, 1'b0);
    tick();
    check("stall1_ewreg", 32'(ewreg), 32'd0);
    check("stall1_edest", 32'(edestReg), 32'd0);
    tick();
    check("stall2_ewreg", 32'(ewreg), 32'd0);
    check("stall2_edest", 32'(edestReg), 32'd0);
    check("add_wdest", 32'(wdestReg), 32'd7);
    check("add_wwreg", 32'(wwreg), 32'd1);
`ifdef CTRL_PIPE_PERF_EN
    check("stall_cnt_two", 32'(stall_cnt), 32'd2);
`endif

    // jal ignores rd/rt and links to r31
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD, 5'd3, 5'd4, 1'b1);
    tick();
    check("jal_edest", 32'(edestReg), 32'd31);
    check("jal_ejal", 32'(ejal), 32'd1);
    check("jal_ewreg", 32'(ewreg), 32'd1);

    // invalid instruction with wreg/wmem set must never write
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OR, 5'd6, 5'd6, 1'b1);
    tick();
    check("inv_ewreg", 32'(ewreg), 32'd0);
    check("inv_ewmem", 32'(ewmem), 32'd0);
    drive_idle();
    tick();
    check("inv_mwreg", 32'(mwreg), 32'd0);
    tick();
    check("inv_wwreg", 32'(wwreg), 32'd0);

    // reset with three instructions in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 5'(10 + i), 5'd1, 1'b1);
      tick();
    end
    clrn = 1'b0;
    tick();
    check("rst_mid_ewreg", 32'(ewreg), 32'd0);
    check("rst_mid_mdest", 32'(mdestReg), 32'd0);
    clrn = 1'b1;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_retire", 32'(retire_cnt), 32'd0);
    end

    // long stall drives stall_cnt into saturation
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5'd8, 5'd8, 1'b0);
    for (int i = 0; i < 20; i++) tick();
`ifdef CTRL_PIPE_PERF_EN
    check("stall_sat", 32'(stall_cnt), 32'(CNT_MAX));
`endif

    // random traffic with occasional stalls and resets
    for (int i = 0; i < 300; i++) begin
      clrn = ($urandom_range(0, 31) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 9)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
